// File: rtl/pll_phase_stepper.sv
// Sequencer for the ECP5 EHXPLLL dynamic fine-phase ports: qualifies PLL lock,
// shapes PHASESEL/PHASEDIR/PHASESTEP per request and tracks per-output phase indices.
//
// state  | meaning
// IDLE   | waiting for step_req; ready when lock is qualified
// SETUP  | phasesel/phasedir driven, phasestep low for SETUP_CYC cycles
// PULSE  | phasestep high for PULSE_CYC cycles
// SETTLE | phasestep low for SETTLE_CYC cycles before reporting done
module pll_phase_stepper #(
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int LOCK_SETTLE = 1024,
  parameter int PHASE_STEPS = 32
) (
  input  logic                           clki,
  input  logic                           rst_n,
  input  logic                           pll_locked,
  input  logic                           step_req,
  input  logic                           step_dir,
  input  logic [1:0]                     step_sel,
  output logic [1:0]                     phasesel,
  output logic                           phasedir,
  output logic                           phasestep,
  output logic                           ready,
  output logic                           busy,
  output logic                           done,
  output logic                           rejected,
  output logic [$clog2(PHASE_STEPS)-1:0] phase_os,
  output logic [$clog2(PHASE_STEPS)-1:0] phase_os2,
  output logic [$clog2(PHASE_STEPS)-1:0] phase_os3
);

  localparam int PW   = $clog2(PHASE_STEPS);
  localparam int CW   = $clog2(LOCK_SETTLE + 1);
  localparam int TMAX = (SETUP_CYC > PULSE_CYC) ?
                        ((SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC) :
                        ((PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC);
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, SETTLE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   lock_cnt;
  logic            lock_m, lock_s, lock_ok;
  logic            accept, reject, step_end, tc;

  // Two-flop synchroniser for the asynchronous PLL lock indication
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n)
      lock_cnt <= '0;
    else if (!lock_s)
      lock_cnt <= '0;
    else if (lock_cnt != CW'(LOCK_SETTLE))
      lock_cnt <= lock_cnt + CW'(1);
  end

  assign lock_ok = (lock_cnt == CW'(LOCK_SETTLE));
  assign ready   = lock_ok && (state_q == IDLE);
  assign tc      = (timer_q == '0);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    accept   = 1'b0;
    reject   = 1'b0;
    step_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (step_req) begin
          if (lock_ok && (step_sel != 2'b11)) begin
            accept  = 1'b1;
            state_d = SETUP;
            timer_d = TW'(SETUP_CYC - 1);
          end else begin
            reject = 1'b1;
          end
        end
      end
      SETUP: begin
        if (tc) begin
          state_d = PULSE;
          timer_d = TW'(PULSE_CYC - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      PULSE: begin
        if (tc) begin
          state_d = SETTLE;
          timer_d = TW'(SETTLE_CYC - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      SETTLE: begin
        if (tc) begin
          state_d  = IDLE;
          step_end = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Step outputs are registered from the next state so PHASESTEP never glitches
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      phasesel  <= 2'b00;
      phasedir  <= 1'b0;
      phasestep <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rejected  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      phasestep <= (state_d == PULSE);
      busy      <= (state_d != IDLE);
      done      <= step_end;
      rejected  <= reject;
      if (accept) begin
        phasesel <= step_sel;
        phasedir <= ~step_dir;
      end
    end
  end

  // PHASE_STEPS is a power of two, so natural wrap of PW bits gives the modulo
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      phase_os  <= '0;
      phase_os2 <= '0;
      phase_os3 <= '0;
    end else if (step_end) begin
      case (phasesel)
        2'b00:   phase_os  <= phasedir ? phase_os  - PW'(1) : phase_os  + PW'(1);
        2'b01:   phase_os2 <= phasedir ? phase_os2 - PW'(1) : phase_os2 + PW'(1);
        2'b10:   phase_os3 <= phasedir ? phase_os3 - PW'(1) : phase_os3 + PW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Directed bench for pll_phase_stepper: lock qualification, step waveform timing,
// index wrap, rejects, ignored requests, lock loss and async reset.
module tb_pll_phase_stepper;

  logic       clki = 1'b0;
  logic       rst_n, pll_locked, step_req, step_dir;
  logic [1:0] step_sel;
  logic [1:0] phasesel;
  logic       phasedir, phasestep, ready, busy, done, rejected;
  logic [4:0] phase_os, phase_os2, phase_os3;

  int n_chk  = 0;
  int n_pass = 0;

  pll_phase_stepper dut (
    .clki       (clki),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .step_req   (step_req),
    .step_dir   (step_dir),
    .step_sel   (step_sel),
    .phasesel   (phasesel),
    .phasedir   (phasedir),
    .phasestep  (phasestep),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .rejected   (rejected),
    .phase_os   (phase_os),
    .phase_os2  (phase_os2),
    .phase_os3  (phase_os3)
  );

  always #5 clki = ~clki;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clki);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 2000) begin
      tick();
      n++;
    end
  endtask

  // Issue one request at edge 0 and observe cycles 1..20.
  task automatic run_step(input logic [1:0] sel, input logic dir,
                          input int extra_at, input int drop_at,
                          output int ps_first, output int ps_cnt,
                          output int done_at, output int done_cnt,
                          output int rej_at, output int busy_cnt,
                          output int stab_err);
    logic [1:0] exp_sel;
    ps_first = 0; ps_cnt = 0; done_at = 0; done_cnt = 0;
    rej_at = 0; busy_cnt = 0; stab_err = 0;
    exp_sel = sel;
    step_sel = sel;
    step_dir = dir;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step_req = (c == extra_at);
      if (c == extra_at) step_dir = ~dir;
      if (c == drop_at) pll_locked = 1'b0;
      if (phasestep) begin
        if (ps_cnt == 0) ps_first = c;
        ps_cnt++;
      end
      if (done) begin
        if (done_cnt == 0) done_at = c;
        done_cnt++;
      end
      if (rejected && rej_at == 0) rej_at = c;
      if (busy) begin
        busy_cnt++;
        if (phasesel != exp_sel || phasedir != ~dir) stab_err++;
      end
      tick();
    end
    step_req = 1'b0;
    step_dir = dir;
  endtask

  int n, psf, psc, dat, dcnt, rat, bcnt, serr;

  initial begin
    rst_n = 1'b0; pll_locked = 1'b0; step_req = 1'b0; step_dir = 1'b0; step_sel = 2'b00;
    tick(); tick();
    check_eq("reset_outputs",
             int'({phasesel, phasedir, phasestep, ready, busy, done, rejected}), 0);
    check_eq("reset_indices", int'({phase_os, phase_os2, phase_os3}), 0);
    rst_n = 1'b1;
    tick();

    // Request before lock qualification
    run_step(2'b00, 1'b1, 0, 0, psf, psc, dat, dcnt, rat, bcnt, serr);
    check_eq("prelock_rej_at", rat, 1);
    check_eq("prelock_no_step", psc + dcnt + bcnt, 0);

    pll_locked = 1'b1;
    wait_ready(n);
    check_eq("lock_ready_cycles", n, 1026);

    // First advance on CLKOS
    run_step(2'b00, 1'b1, 0, 0, psf, psc, dat, dcnt, rat, bcnt, serr);
    check_eq("os_ps_first", psf, 3);
    check_eq("os_ps_cnt", psc, 4);
    check_eq("os_done_at", dat, 15);
    check_eq("os_done_cnt", dcnt, 1);
    check_eq("os_busy_cnt", bcnt, 14);
    check_eq("os_stable", serr, 0);
    check_eq("os_sel_dir", int'({phasesel, phasedir}), 0);
    check_eq("os_idx", int'({phase_os, phase_os2, phase_os3}), {5'd1, 5'd0, 5'd0});

    // 32 advances on CLKOS2 wrap back to 0
    for (int i = 0; i < 32; i++) begin
      run_step(2'b01, 1'b1, 0, 0, psf, psc, dat, dcnt, rat, bcnt, serr);
      if (i == 30) check_eq("os2_idx_31", int'(phase_os2), 31);
    end
    check_eq("os2_wrap", int'(phase_os2), 0);
    check_eq("os2_os_kept", int'(phase_os), 1);

    // Retard on CLKOS3 wraps 0 -> 31
    run_step(2'b10, 1'b0, 0, 0, psf, psc, dat, dcnt, rat, bcnt, serr);
    check_eq("os3_sel_dir", int'({phasesel, phasedir}), 5);
    check_eq("os3_stable", serr, 0);
    check_eq("os3_retard", int'(phase_os3), 31);
    check_eq("os3_others", int'({phase_os, phase_os2}), {5'd1, 5'd0});

    // CLKOP select is refused
    run_step(2'b11, 1'b1, 0, 0, psf, psc, dat, dcnt, rat, bcnt, serr);
    check_eq("clkop_rej_at", rat, 1);
    check_eq("clkop_no_step", psc + dcnt + bcnt, 0);
    check_eq("clkop_idx", int'({phase_os, phase_os2, phase_os3}), {5'd1, 5'd0, 5'd31});

    // Second request mid-sequence is ignored
    run_step(2'b00, 1'b1, 5, 0, psf, psc, dat, dcnt, rat, bcnt, serr);
    check_eq("busy_req_ps_cnt", psc, 4);
    check_eq("busy_req_done_cnt", dcnt, 1);
    check_eq("busy_req_no_rej", rat, 0);
    check_eq("busy_req_idx", int'(phase_os), 2);

    // Lock lost during PULSE: sequence completes, ready waits for relock
    run_step(2'b10, 1'b1, 0, 4, psf, psc, dat, dcnt, rat, bcnt, serr);
    check_eq("lockdrop_ps_first", psf, 3);
    check_eq("lockdrop_ps_cnt", psc, 4);
    check_eq("lockdrop_done_at", dat, 15);
    check_eq("lockdrop_idx", int'(phase_os3), 0);
    check_eq("lockdrop_not_ready", int'(ready), 0);
    pll_locked = 1'b1;
    wait_ready(n);
    check_eq("relock_ready_cycles", n, 1026);

    // Async reset during PULSE
    step_sel = 2'b01; step_dir = 1'b1; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick(); tick(); tick();
    check_eq("rst_pre_ps", int'(phasestep), 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_ps_busy", int'({phasestep, busy}), 0);
    check_eq("rst_async_idx", int'({phase_os, phase_os2, phase_os3}), 0);
    tick();
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
